// File: rtl/selector_rr_n_pkg.sv
// Shared constants for the N-channel word selector and its arbiter.
package selector_rr_n_pkg;

    localparam int SEL_MODE_FIXED = 0;
    localparam int SEL_MODE_RR    = 1;
    localparam int SEL_MODE_EXT   = 2;

endpackage

// File: rtl/selector_rr_n_arbiter.sv
// Combinational arbiter: one-hot grant plus encoded index for fixed, round-robin or steered selection.
module rr_arbiter_n
    import selector_rr_n_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int MODE     = SEL_MODE_RR,
    localparam int CW       = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] in_valid,
    input  logic [CW-1:0]       ptr,
    input  logic [CW-1:0]       sel_ext,
    output logic [CHANNELS-1:0] grant,
    output logic [CW-1:0]       idx,
    output logic                any
);

    logic [CW-1:0] start;
    logic          hi_hit, lo_hit;
    logic [CW-1:0] hi_idx, lo_idx;

    // Fixed priority is a rotating search that always starts at channel 0.
    assign start = (MODE == SEL_MODE_RR) ? ptr : '0;

    always_comb begin
        idx    = '0;
        any    = 1'b0;
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        // Descending scan leaves the lowest qualifying index in hi_idx / lo_idx.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (MODE == SEL_MODE_EXT) begin
                if (in_valid[i] && sel_ext == CW'(i)) begin
                    any = 1'b1;
                    idx = CW'(i);
                end
            end else if (in_valid[i]) begin
                if (i >= int'(start)) begin
                    hi_hit = 1'b1;
                    hi_idx = CW'(i);
                end
                lo_hit = 1'b1;
                lo_idx = CW'(i);
            end
        end
        if (MODE != SEL_MODE_EXT) begin
            any = hi_hit | lo_hit;
            idx = hi_hit ? hi_idx : lo_idx;
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < CHANNELS; i++)
            grant[i] = any && (idx == CW'(i));
    end

endmodule

// File: rtl/selector_rr_n.sv
// N-channel valid/ready merger onto one registered output stream tagged with its source channel.
module selector_rr_n
    import selector_rr_n_pkg::*;
#(
    parameter  int BITWIDTH = 8,
    parameter  int CHANNELS = 4,
    parameter  int MODE     = SEL_MODE_RR,
    parameter  int DEBUG    = 0,
    localparam int CW       = $clog2(CHANNELS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*BITWIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]          in_valid,
    output logic [CHANNELS-1:0]          in_ready,
    input  logic [CW-1:0]                sel_ext,
    output logic [BITWIDTH-1:0]          out_data,
    output logic [CW-1:0]                out_chan,
    output logic                         out_valid,
    input  logic                         out_ready
);

    generate
        if (CHANNELS < 2 || BITWIDTH < 1 || MODE < 0 || MODE > 2 || DEBUG < 0 || DEBUG > 1) begin : g_bad_param
            $error("selector_rr_n: illegal parameter combination");
        end
    endgenerate

    logic [CHANNELS-1:0] grant;
    logic [CW-1:0]       gidx, ptr, ptr_nxt;
    logic                any, load_en;
    logic [BITWIDTH-1:0] sel_data;

    rr_arbiter_n #(.CHANNELS(CHANNELS), .MODE(MODE)) u_arb (
        .in_valid (in_valid),
        .ptr      (ptr),
        .sel_ext  (sel_ext),
        .grant    (grant),
        .idx      (gidx),
        .any      (any)
    );

    // Output register is free when empty or being drained this cycle.
    assign load_en  = !out_valid | out_ready;
    assign in_ready = grant & {CHANNELS{load_en}};
    assign ptr_nxt  = (gidx == CW'(CHANNELS - 1)) ? '0 : gidx + 1'b1;

    // Mux keyed by the one-hot grant keeps in_data off the in_ready path.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (grant[i]) sel_data |= in_data[i*BITWIDTH +: BITWIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            out_valid <= any;
            if (any) begin
                out_data <= sel_data;
                out_chan <= gidx;
                ptr      <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_selector_rr_n.sv
// Bench: three selector instances (round-robin/4, fixed/4, steered/3) against a queue-free behavioural model.
module tb_selector_rr_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  vld;
    logic [31:0] dat;
    logic [1:0]  sel;
    logic        ordy;

    logic [3:0] rr_ir, fp_ir;
    logic [2:0] ex_ir;
    logic [7:0] rr_od, fp_od, ex_od;
    logic [1:0] rr_oc, fp_oc, ex_oc;
    logic       rr_ov, fp_ov, ex_ov;

    always #5 clk = ~clk;

    selector_rr_n #(.BITWIDTH(8), .CHANNELS(4), .MODE(1), .DEBUG(0)) u_rr (
        .clk(clk), .rst(rst), .in_data(dat), .in_valid(vld), .in_ready(rr_ir), .sel_ext(sel),
        .out_data(rr_od), .out_chan(rr_oc), .out_valid(rr_ov), .out_ready(ordy));
    selector_rr_n #(.BITWIDTH(8), .CHANNELS(4), .MODE(0), .DEBUG(0)) u_fp (
        .clk(clk), .rst(rst), .in_data(dat), .in_valid(vld), .in_ready(fp_ir), .sel_ext(sel),
        .out_data(fp_od), .out_chan(fp_oc), .out_valid(fp_ov), .out_ready(ordy));
    selector_rr_n #(.BITWIDTH(8), .CHANNELS(3), .MODE(2), .DEBUG(0)) u_ex (
        .clk(clk), .rst(rst), .in_data(dat[23:0]), .in_valid(vld[2:0]), .in_ready(ex_ir), .sel_ext(sel),
        .out_data(ex_od), .out_chan(ex_oc), .out_valid(ex_ov), .out_ready(ordy));

    logic [3:0] a_ir[3];
    logic [7:0] a_od[3];
    logic [1:0] a_oc[3];
    logic       a_ov[3];
    always_comb begin
        a_ir[0] = rr_ir; a_ir[1] = fp_ir; a_ir[2] = {1'b0, ex_ir};
        a_od[0] = rr_od; a_od[1] = fp_od; a_od[2] = ex_od;
        a_oc[0] = rr_oc; a_oc[1] = fp_oc; a_oc[2] = ex_oc;
        a_ov[0] = rr_ov; a_ov[1] = fp_ov; a_ov[2] = ex_ov;
    end

    // Model state per instance: 0 = round-robin, 1 = fixed, 2 = steered.
    int md[3] = '{1, 0, 2};
    int nc[3] = '{4, 4, 3};
    int m_ov[3], m_od[3], m_oc[3], m_ptr[3];
    int last_ir[3];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Which channel wins, straight from the selection rules; -1 means none.
    function automatic int pick(input int mode, input int ch, input logic [3:0] v, input int p, input int s);
        if (mode == 0) begin
            for (int i = 0; i < ch; i++) if (v[i]) return i;
        end else if (mode == 1) begin
            for (int k = 0; k < ch; k++) if (v[(p + k) % ch]) return (p + k) % ch;
        end else begin
            if (s < ch && v[s]) return s;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            m_ov[m] = 0; m_od[m] = 0; m_oc[m] = 0; m_ptr[m] = 0;
        end
    endtask

    // One clock: check in_ready against the model, advance the model, check registered outputs.
    task automatic step();
        int g;
        bit le;
        #1;
        for (int m = 0; m < 3; m++) begin
            le = (m_ov[m] == 0) || ordy;
            g  = le ? pick(md[m], nc[m], vld, m_ptr[m], int'(sel)) : -1;
            chk($sformatf("in_ready[%0d]", m), int'(a_ir[m]), (g >= 0) ? (1 << g) : 0);
            last_ir[m] = int'(a_ir[m]);
            if (le) begin
                if (g >= 0) begin
                    m_ov[m]  = 1;
                    m_od[m]  = int'((dat >> (g * 8)) & 32'hFF);
                    m_oc[m]  = g;
                    m_ptr[m] = (g + 1) % nc[m];
                end else begin
                    m_ov[m] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("out_valid[%0d]", m), int'(a_ov[m]), m_ov[m]);
            chk($sformatf("out_data[%0d]", m), int'(a_od[m]), m_od[m]);
            chk($sformatf("out_chan[%0d]", m), int'(a_oc[m]), m_oc[m]);
        end
    endtask

    task automatic mid_reset();
        #3 rst = 1'b1;
        #1;
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("async_rst_valid[%0d]", m), int'(a_ov[m]), 0);
            chk($sformatf("async_rst_data[%0d]", m), int'(a_od[m]), 0);
        end
        model_reset();
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vld = '0; dat = '0; sel = '0; ordy = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("reset_valid[%0d]", m), int'(a_ov[m]), 0);
            chk($sformatf("reset_data[%0d]", m), int'(a_od[m]), 0);
            chk($sformatf("reset_chan[%0d]", m), int'(a_oc[m]), 0);
        end
        rst = 1'b0;

        // Round-robin rotation with all channels valid
        vld = 4'b1111; dat = 32'h44332211; ordy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_rotate_chan", int'(rr_oc), k % 4);
            chk("rr_rotate_valid", int'(rr_ov), 1);
        end

        // Fixed priority starves ch2 while ch1 is valid
        vld = 4'b0110; dat = 32'h00B2A100;
        repeat (3) begin
            step();
            chk("fp_starve_data", int'(fp_od), 8'hA1);
            chk("fp_starve_chan", int'(fp_oc), 1);
        end
        vld = 4'b0100;
        step();
        chk("fp_next_data", int'(fp_od), 8'hB2);
        chk("fp_next_chan", int'(fp_oc), 2);

        // Backpressure holds the word and blocks all inputs
        vld = 4'b0001; dat = 32'h0000005C;
        step();
        chk("bp_load", int'(fp_od), 8'h5C);
        ordy = 1'b0; vld = 4'b1111; dat = 32'h99887766;
        repeat (5) begin
            step();
            chk("bp_hold_data", int'(fp_od), 8'h5C);
            chk("bp_in_ready", last_ir[1], 0);
        end
        ordy = 1'b1;
        step();
        chk("bp_release_ready", last_ir[1], 1);
        chk("bp_release_data", int'(fp_od), 8'h66);

        // Out-of-range steering index grants nothing
        sel = 2'd3; vld = 4'b0111;
        step();
        chk("ext_oor_ready", last_ir[2], 0);
        chk("ext_oor_valid", int'(ex_ov), 0);
        sel = 2'd2;
        step();
        chk("ext_sel_chan", int'(ex_oc), 2);
        chk("ext_sel_data", int'(ex_od), 8'h88);

        // Asynchronous reset while full, then round-robin restarts at ch0
        vld = 4'b1111; ordy = 1'b0;
        step();
        chk("rst_pre_full", int'(rr_ov), 1);
        mid_reset();
        ordy = 1'b1;
        step();
        chk("rst_post_chan", int'(rr_oc), 0);
        chk("rst_post_valid", int'(rr_ov), 1);

        // Pointer wraps from ch3 to ch0 with no bubble
        vld = 4'b1000;
        step();
        chk("wrap_ch3", int'(rr_oc), 3);
        vld = 4'b1001;
        step();
        chk("wrap_ch0", int'(rr_oc), 0);
        chk("wrap_no_bubble", int'(rr_ov), 1);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            vld  = 4'($urandom);
            dat  = $urandom;
            sel  = 2'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            step();
            if ($urandom_range(0, 63) == 0) mid_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
